// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Iterative 32x32 multiply / 32/32 divide unit producing HI/LO
//                write strobes, one radix-2 step per cycle.
//  Revision    : 1.0  initial release
// ============================================================================

module muldiv_unit #(
    parameter bit EARLY_ZERO = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic        hi_we,
    output logic [31:0] hi_wdata,
    output logic        lo_we,
    output logic [31:0] lo_wdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        WB   = 2'd3
    } state_t;

    localparam logic [4:0] c_LAST_STEP = 5'd31;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [4:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_opb;
    logic        r_is_div;
    logic        r_neg_q;
    logic        r_neg_r;

    logic        r_busy;
    logic        r_hi_we;
    logic        r_lo_we;
    logic [31:0] r_hi_wdata;
    logic [31:0] r_lo_wdata;

    logic        w_accept;
    logic        w_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic        w_b_zero;
    logic        w_early;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;

    logic [32:0] w_mul_sum;
    logic [32:0] w_div_tmp;
    logic        w_div_ge;
    logic [31:0] w_div_diff;

    logic [63:0] w_prod_fix;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;
    logic [31:0] w_fix_hi;
    logic [31:0] w_fix_lo;

    // ------------------------------------------------------------------
    // Accept-time operand conditioning
    // ------------------------------------------------------------------
    assign w_accept = (r_state == IDLE) && start && !flush;
    assign w_signed = ~op[0];
    assign w_a_neg  = w_signed & a[31];
    assign w_b_neg  = w_signed & b[31];
    assign w_b_zero = (b == 32'd0);
    assign w_mag_a  = w_a_neg ? (~a + 32'd1) : a;
    assign w_mag_b  = w_b_neg ? (~b + 32'd1) : b;
    assign w_early  = EARLY_ZERO && !op[1] && ((a == 32'd0) || w_b_zero);

    // ------------------------------------------------------------------
    // Per-cycle iteration datapath
    // ------------------------------------------------------------------
    assign w_mul_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : 33'd0);
    assign w_div_tmp  = {r_hi, r_lo[31]};
    assign w_div_ge   = (w_div_tmp >= {1'b0, r_opb});
    // When the subtract is taken the true difference is below the divisor,
    // so the low 32 bits are exact.
    assign w_div_diff = w_div_tmp[31:0] - r_opb;

    // ------------------------------------------------------------------
    // Sign fix-up
    // ------------------------------------------------------------------
    assign w_prod_fix = r_neg_q ? (~{r_hi, r_lo} + 64'd1) : {r_hi, r_lo};
    assign w_quo_fix  = r_neg_q ? (~r_lo + 32'd1) : r_lo;
    assign w_rem_fix  = r_neg_r ? (~r_hi + 32'd1) : r_hi;
    assign w_fix_hi   = r_is_div ? w_rem_fix : w_prod_fix[63:32];
    assign w_fix_lo   = r_is_div ? w_quo_fix : w_prod_fix[31:0];

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_early ? WB : ITER;
                end
            end
            ITER: begin
                if (flush) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == c_LAST_STEP) begin
                    w_state_nxt = FIX;
                end
            end
            FIX: begin
                w_state_nxt = flush ? IDLE : WB;
            end
            WB: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand / accumulator registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= 5'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_opb    <= 32'd0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else if (w_accept) begin
            r_cnt    <= 5'd0;
            r_hi     <= 32'd0;
            r_lo     <= op[1] ? w_mag_a : w_mag_b;
            r_opb    <= op[1] ? w_mag_b : w_mag_a;
            r_is_div <= op[1];
            // Divide by zero keeps the all-ones quotient; the remainder still
            // takes a's sign, which restores a exactly.
            r_neg_q  <= (w_a_neg ^ w_b_neg) & ~(op[1] & w_b_zero);
            r_neg_r  <= w_a_neg;
        end else if (r_state == ITER) begin
            r_cnt <= r_cnt + 5'd1;
            if (r_is_div) begin
                r_hi <= w_div_ge ? w_div_diff : w_div_tmp[31:0];
                r_lo <= {r_lo[30:0], w_div_ge};
            end else begin
                r_hi <= w_mul_sum[32:1];
                r_lo <= {w_mul_sum[0], r_lo[31:1]};
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs, derived from the next state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy     <= 1'b0;
            r_hi_we    <= 1'b0;
            r_lo_we    <= 1'b0;
            r_hi_wdata <= 32'd0;
            r_lo_wdata <= 32'd0;
        end else begin
            r_busy  <= (w_state_nxt != IDLE);
            r_hi_we <= (w_state_nxt == WB);
            r_lo_we <= (w_state_nxt == WB);
            if ((r_state == FIX) && (w_state_nxt == WB)) begin
                r_hi_wdata <= w_fix_hi;
                r_lo_wdata <= w_fix_lo;
            end else if ((r_state == IDLE) && (w_state_nxt == WB)) begin
                r_hi_wdata <= 32'd0;
                r_lo_wdata <= 32'd0;
            end
        end
    end

    assign busy     = r_busy;
    assign hi_we    = r_hi_we;
    assign lo_we    = r_lo_we;
    assign hi_wdata = r_hi_wdata;
    assign lo_wdata = r_lo_wdata;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_unit
//  Description : Directed vector bench for muldiv_unit (EARLY_ZERO 0 and 1).
//  Revision    : 1.0  initial release
// ============================================================================

module tb_muldiv_unit;

    localparam logic [1:0] c_MULT  = 2'b00;
    localparam logic [1:0] c_MULTU = 2'b01;
    localparam logic [1:0] c_DIV   = 2'b10;
    localparam logic [1:0] c_DIVU  = 2'b11;
    localparam int         c_NVEC  = 13;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;

    logic        busy, hi_we, lo_we;
    logic [31:0] hi_wdata, lo_wdata;
    logic        ez_busy, ez_hi_we, ez_lo_we;
    logic [31:0] ez_hi_wdata, ez_lo_wdata;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs [c_NVEC];

    muldiv_unit #(.EARLY_ZERO(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .hi_we(hi_we), .hi_wdata(hi_wdata),
        .lo_we(lo_we), .lo_wdata(lo_wdata)
    );

    muldiv_unit #(.EARLY_ZERO(1'b1)) dut_ez (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(ez_busy), .hi_we(ez_hi_we), .hi_wdata(ez_hi_wdata),
        .lo_we(ez_lo_we), .lo_wdata(ez_lo_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Caller is at a negedge with the unit idle.
    task automatic run_op(input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb,
                          input logic [31:0] eh, input logic [31:0] el,
                          input bit chk_ez, input int inj_k);
        bit busy_bad = 0;
        bit we_bad   = 0;
        bit ez_bad   = 0;
        chk("accept_cycle_busy", {63'd0, busy}, 64'd0);
        start = 1'b1; op = o; a = aa; b = bb;
        @(posedge clk);
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk);
            if (busy !== (k <= 34)) busy_bad = 1;
            if ((hi_we !== (k == 34)) || (lo_we !== (k == 34))) we_bad = 1;
            if (chk_ez && ((ez_busy !== (k <= 34)) || (ez_hi_we !== (k == 34)) ||
                           (ez_lo_we !== (k == 34)))) ez_bad = 1;
            if (k == 34) begin
                chk("hi_wdata", {32'd0, hi_wdata}, {32'd0, eh});
                chk("lo_wdata", {32'd0, lo_wdata}, {32'd0, el});
                if (chk_ez) begin
                    chk("ez_hi_wdata", {32'd0, ez_hi_wdata}, {32'd0, eh});
                    chk("ez_lo_wdata", {32'd0, ez_lo_wdata}, {32'd0, el});
                end
            end
            if (k == 36) begin
                chk("hold_wdata", {hi_wdata, lo_wdata}, {eh, el});
            end
            if (k == inj_k) begin
                start = 1'b1; op = c_MULTU; a = 32'h0000_5555; b = 32'h0000_0003;
            end else begin
                start = 1'b0; a = $urandom; b = $urandom;
            end
        end
        chk("busy_window", {63'd0, busy_bad}, 64'd0);
        chk("strobe_timing", {63'd0, we_bad}, 64'd0);
        if (chk_ez) chk("ez_timing", {63'd0, ez_bad}, 64'd0);
    endtask

    task automatic run_flush(input int fk);
        bit we_seen = 0;
        start = 1'b1; op = c_MULTU; a = 32'd3; b = 32'd5;
        @(posedge clk);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (hi_we || lo_we || ez_hi_we || ez_lo_we) we_seen = 1;
            if (k == fk + 1) begin
                chk("flush_busy", {62'd0, busy, ez_busy}, 64'd0);
            end
            start = 1'b0;
            flush = (k == fk);
        end
        flush = 1'b0;
        chk("flush_no_strobe", {63'd0, we_seen}, 64'd0);
    endtask

    initial begin
        vecs[0]  = '{c_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[1]  = '{c_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2]  = '{c_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{c_DIVU,  32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003};
        vecs[4]  = '{c_DIVU,  32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF};
        vecs[5]  = '{c_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[6]  = '{c_MULT,  32'h0000_0007, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFDD};
        vecs[7]  = '{c_DIVU,  32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000};
        vecs[8]  = '{c_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
        vecs[9]  = '{c_DIV,   32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2};
        vecs[10] = '{c_DIV,   32'hFFFF_FFF8, 32'h0000_0000, 32'hFFFF_FFF8, 32'hFFFF_FFFF};
        vecs[11] = '{c_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF};
        vecs[12] = '{c_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};

        rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
        #3;
        chk("reset_flags", {59'd0, busy, hi_we, lo_we, ez_busy, ez_hi_we}, 64'd0);
        chk("reset_wdata", {hi_wdata, lo_wdata}, 64'd0);

        // Release and issue in the same cycle: the first edge after release accepts.
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < c_NVEC; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, 1'b1,
                   (i == 3) ? 5 : 0);
        end

        // Reset in the middle of a divide.
        begin
            bit we_seen = 0;
            start = 1'b1; op = c_DIV; a = 32'd100; b = 32'hFFFF_FFF9;
            @(posedge clk);
            for (int k = 1; k <= 20; k++) begin
                @(negedge clk);
                start = 1'b0;
            end
            rst_n = 1'b0;
            #1;
            chk("async_rst_flags", {61'd0, busy, hi_we, lo_we}, 64'd0);
            chk("async_rst_wdata", {hi_wdata, lo_wdata}, 64'd0);
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                if (hi_we || lo_we || busy) we_seen = 1;
            end
            chk("rst_no_strobe", {63'd0, we_seen}, 64'd0);
            rst_n = 1'b1;
            run_op(c_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 1'b1, 0);
        end

        run_flush(10);
        run_flush(33);

        // start together with flush in IDLE must not be accepted.
        start = 1'b1; flush = 1'b1; op = c_DIVU; a = 32'd9; b = 32'd3;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("idle_flush_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        chk("idle_flush_quiet", {62'd0, busy, hi_we}, 64'd0);

        // Put nonzero data on the write ports before the early-zero check.
        run_op(c_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b1, 0);

        // Early-zero multiply: EARLY_ZERO=1 writes at N+1, EARLY_ZERO=0 at N+34.
        start = 1'b1; op = c_MULT; a = 32'd0; b = 32'h0000_1234;
        @(posedge clk);
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 1) begin
                chk("ez_wb_strobes", {61'd0, ez_hi_we, ez_lo_we, ez_busy}, 64'd7);
                chk("ez_wb_data", {ez_hi_wdata, ez_lo_wdata}, 64'd0);
                chk("noez_still_busy", {62'd0, busy, hi_we}, 64'd2);
            end
            if (k == 2) begin
                chk("ez_done", {62'd0, ez_busy, ez_hi_we}, 64'd0);
            end
            if (k == 34) begin
                chk("noez_zero_wb", {31'd0, hi_we, hi_wdata}, {31'd0, 1'b1, 32'd0});
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter EARLY_ZERO, default 0; when 1, an operation with a zero operand skips iteration.
REQ-002 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port rst_n  input  1  asynchronous reset, active-low.
REQ-004 SHALL have port start  input  1  request to begin the operation named by op.
REQ-005 SHALL have port op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port a  input  32  operand rs: multiplicand or dividend.
REQ-007 SHALL have port b  input  32  operand rt: multiplier or divisor.
REQ-008 SHALL have port flush  input  1  abort the in-flight operation; no HI/LO write.
REQ-009 SHALL have port busy  output  1  unit occupied; the pipeline stalls MFHI/MFLO and new mul/div.
REQ-010 SHALL have port hi_we  output  1  one-cycle write strobe to the HI register.
REQ-011 SHALL have port hi_wdata  output  32  HI write data.
REQ-012 SHALL have port lo_we  output  1  one-cycle write strobe to the LO register.
REQ-013 SHALL have port lo_wdata  output  32  LO write data.

Function
REQ-014 SHALL implement states IDLE, ITER, FIX and WB, all outputs registered.
REQ-015 IDLE: start=1 and flush=0 at an edge SHALL latch a, b and op, and move to ITER with iteration counter = 0.
REQ-016 Start SHALL be ignored outside IDLE; operands are sampled only at the accepting edge.
REQ-017 For signed ops, the unit SHALL convert operands to magnitudes at accept and record the result signs.
- Product and quotient sign = a[31] xor b[31].
- Remainder sign = a[31].
REQ-018 ITER, multiply: SHALL do 32 radix-2 shift-add steps over the 64-bit accumulator {hi,lo}, one step per cycle.
REQ-019 ITER, divide: SHALL do 32 restoring shift-subtract steps over the 33-bit partial remainder, one quotient bit per cycle.
REQ-020 After counter = 31, the unit SHALL go to FIX, which applies two's-complement negation per the recorded signs (unsigned ops: pass-through).
REQ-021 WB: hi_we = lo_we = 1 for exactly one cycle; the next state is IDLE.
REQ-022 Multiply write data: HI = product[63:32], LO = product[31:0].
REQ-023 Divide write data: LO = quotient, HI = remainder.
REQ-024 Latency with EARLY_ZERO=0 SHALL be fixed:
- Accepting edge N.
- ITER occupies cycles N+1..N+32.
- FIX occupies cycle N+33.
- WB occupies cycle N+34.
- busy = 1 from cycle N+1 through N+34 inclusive.
REQ-025 busy SHALL be 0 in IDLE, including the accept cycle itself.
- The pipeline issues start combinationally from ~busy.
REQ-026 Divide by zero (b=0, DIV or DIVU) SHALL write HI = a and LO = 32'hFFFFFFFF, with normal latency.
REQ-027 DIV of 32'h80000000 by 32'hFFFFFFFF SHALL write LO = 32'h80000000 and HI = 0 (wrap, no exception).
REQ-028 When EARLY_ZERO=1 and the accepted op is a multiply with a=0 or b=0, the unit SHALL go IDLE->WB directly.
- WB in cycle N+1 writes HI = LO = 0.
- Divides are unaffected.
REQ-029 flush=1 in ITER or FIX SHALL return the unit to IDLE at that edge: no WB, busy = 0 in the following cycle.
REQ-030 flush=1 during WB SHALL NOT cancel that cycle's write; the write is already committed.
REQ-031 flush=1 with start=1 in IDLE SHALL NOT accept the operation.
REQ-032 hi_wdata and lo_wdata SHALL hold their last value outside WB; consumers qualify them with the strobes only.

Reset
REQ-033 rst_n=0 SHALL immediately, without waiting for clk, set:
- state = IDLE
- busy = 0
- hi_we = lo_we = 0
- hi_wdata = lo_wdata = 0
- iteration counter = 0
REQ-034 Reset mid-operation SHALL discard the operation with no write strobe, either during reset or after release.
REQ-035 The first start SHALL be accepted at the first rising edge after rst_n deasserts.

Verification
REQ-036 MULT a=32'hFFFFFFFE (-2), b=3 accepted at edge N -> WB at N+34 with HI=32'hFFFFFFFF, LO=32'hFFFFFFFA; busy high for exactly 34 cycles.
REQ-037 MULTU a=b=32'hFFFFFFFF -> HI=32'hFFFFFFFE, LO=32'h00000001.
REQ-038 Signed and unsigned divides:
- DIV a=-7, b=2 -> LO=32'hFFFFFFFD (-3), HI=32'hFFFFFFFF (-1).
- DIVU a=7, b=2 -> LO=3, HI=1.
REQ-039 Divide by zero and overflow:
- DIVU a=32'h12345678, b=0 -> HI=32'h12345678, LO=32'hFFFFFFFF.
- DIV 32'h80000000 / -1 -> LO=32'h80000000, HI=0.
REQ-040 Flush and start handling:
- Start MULTU, then flush at cycle N+10 -> no hi_we/lo_we at any cycle; busy=0 from N+11.
- A start presented during busy is ignored.
REQ-041 Reset and early-zero:
- Assert rst_n=0 at cycle N+20 of a DIV -> outputs zero asynchronously, no strobe.
- With EARLY_ZERO=1, MULT a=0 -> WB at N+1, HI=LO=0.
